// File: rtl/muldiv_iter_if.sv
// muldiv_iter_if: operand/result bus and start/busy/done handshake of muldiv_iter.
// master drives operands and the start request; slave returns status and HI/LO.
interface muldiv_iter_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] DA;
  logic [WIDTH-1:0] DB;
  logic [2:0]       op;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output DA, DB, op, start, input busy, done, HI, LO);
  modport slave  (input DA, DB, op, start, output busy, done, HI, LO);
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative HI/LO multiply/divide unit.
// A radix-2 shift-add multiplier and a restoring divider share one rem/quo
// register pair. Operands are reduced to magnitudes on entry and the result
// sign is fixed up in a single FIX cycle before HI/LO are written.
// Optional feature: define MULDIV_FAST_MUL_EN to compute mult/multu with a
// single-cycle array multiplier (IDLE -> FIX directly). Division always iterates.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_iter_if.slave bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial product high half / partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;     // multiplier bits / dividend bits shifting into quotient
  logic [WIDTH-1:0] b_q, b_d;         // |multiplicand| or |divisor|
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;         // negate product (mult) or quotient (div)
  logic             neg_rem_q, neg_rem_d; // negate remainder (div)
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             signed_op_s;
  logic             sign_a_s;
  logic             sign_b_s;
  logic             b_zero_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH:0]   div_diff_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_fix_s;

  // Two's-complement negation of a WIDTH-bit value.
  function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] x);
    return {WIDTH{1'b0}} - x;
  endfunction

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod_s;

  // Single-cycle magnitude product used when the fast multiplier is built in.
  always_comb begin
    fast_prod_s = {{WIDTH{1'b0}}, mag_a_s} * {{WIDTH{1'b0}}, mag_b_s};
  end
`endif

  // Operand conditioning: signed ops (mult, div) work on magnitudes.
  always_comb begin
    signed_op_s = ~bus.op[2] & ~bus.op[0];
    sign_a_s    = signed_op_s & bus.DA[WIDTH-1];
    sign_b_s    = signed_op_s & bus.DB[WIDTH-1];
    mag_a_s     = sign_a_s ? negate_w(bus.DA) : bus.DA;
    mag_b_s     = sign_b_s ? negate_w(bus.DB) : bus.DB;
    b_zero_s    = (bus.DB == {WIDTH{1'b0}});
  end

  // One iteration step for each algorithm plus the signed product fix-up.
  always_comb begin
    mul_sum_s   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_shift_s = {rem_q, quo_q[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, b_q};
    prod_s      = {rem_q, quo_q};
    prod_fix_s  = neg_q ? ({(2*WIDTH){1'b0}} - prod_s) : prod_s;
  end

  // Control FSM next state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (~bus.op[2]) begin
            rem_d     = {WIDTH{1'b0}};
            quo_d     = mag_a_s;
            b_d       = mag_b_s;
            cnt_d     = {CW{1'b0}};
            is_div_d  = bus.op[1];
            neg_rem_d = sign_a_s;
            // Divide by zero must leave the all-ones quotient uncorrected.
            neg_d     = (sign_a_s ^ sign_b_s) & ~(bus.op[1] & b_zero_s);
`ifdef MULDIV_FAST_MUL_EN
            if (~bus.op[1]) begin
              {rem_d, quo_d} = fast_prod_s;
              state_d        = ST_FIX;
            end else begin
              state_d = ST_CALC;
            end
`else
            state_d = ST_CALC;
`endif
          end else if (~bus.op[1]) begin
            if (bus.op[0]) begin
              lo_d = bus.DA;
            end else begin
              hi_d = bus.DA;
            end
          end else begin
            state_d = ST_IDLE;  // reserved op codes do nothing
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CALC: begin
        if (is_div_q) begin
          if (div_diff_s[WIDTH]) begin
            rem_d = div_shift_s[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end else begin
            rem_d = div_diff_s[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end
        end else begin
          rem_d = mul_sum_s[WIDTH:1];
          quo_d = {mul_sum_s[0], quo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_CALC;
        end
      end

      ST_FIX: begin
        if (is_div_q) begin
          hi_d = neg_rem_q ? negate_w(rem_q) : rem_q;
          lo_d = neg_q ? negate_w(quo_q) : quo_q;
        end else begin
          hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
          lo_d = prod_fix_s[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CW{1'b0}};
      rem_q     <= {WIDTH{1'b0}};
      quo_q     <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule
